// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the shared-transmitter arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 8
) ();
  localparam int unsigned ID_W = $clog2(NREQ);

  logic                     en;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*DATA_W-1:0]   req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     tx_en;
  logic                     tx_start;
  logic [DATA_W-1:0]        tx_in;
  logic                     tx_busy;
  logic                     tx_done;
  logic                     busy;
  logic [ID_W-1:0]          gnt_id;
  logic [NREQ-1:0]          done;
  logic                     err;

  // Client/uart_tx environment side.
  modport master (
    output en, req_valid, req_data, tx_busy, tx_done,
    input  req_ready, tx_en, tx_start, tx_in, busy, gnt_id, done, err
  );

  // Arbiter side.
  modport slave (
    input  en, req_valid, req_data, tx_busy, tx_done,
    output req_ready, tx_en, tx_start, tx_in, busy, gnt_id, done, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte producers.
// Grants one byte at a time, tracks tx_busy/tx_done to completion or timeout.
module uart_tx_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_tx_arbiter_if.slave  io_bus
);
  localparam int unsigned      ID_W     = $clog2(NREQ);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [ID_W-1:0]  LastInit = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StRelease} state_e;

  state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_last, w_last_nxt;
  logic [ID_W-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic [DATA_W-1:0] r_tx_in, w_tx_in_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic              r_err, w_err_nxt;
  logic [NREQ-1:0]   r_done, w_done_nxt;
  logic [NREQ-1:0]   w_ready;
  logic [ID_W-1:0]   w_winner, w_idx;
  logic              w_any, w_timeout;

  // Round-robin pick: scan farthest offset first so the nearest hit after r_last wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      w_idx = ID_W'((int'(r_last) + k) % int'(NREQ));
      if (io_bus.req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Saturating counter, so >= keeps the abort condition true once reached.
  assign w_timeout = (r_cnt >= CntLimit);

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_gnt_id_nxt   = r_gnt_id;
    w_tx_in_nxt    = r_tx_in;
    w_cnt_nxt      = r_cnt;
    w_tx_start_nxt = r_tx_start;
    w_done_nxt     = '0;
    w_err_nxt      = 1'b0;
    w_ready        = '0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.en && w_any) begin
          w_ready[w_winner] = 1'b1;
          w_tx_in_nxt       = io_bus.req_data[32'(w_winner) * DATA_W +: DATA_W];
          w_gnt_id_nxt      = w_winner;
          w_last_nxt        = w_winner;
          w_cnt_nxt         = '0;
          w_tx_start_nxt    = 1'b1;
          w_state_nxt       = StStart;
        end
      end
      StStart: begin
        if (r_cnt != CntMax) w_cnt_nxt = r_cnt + 1'b1;
        if (io_bus.tx_busy || io_bus.tx_done) begin
          w_tx_start_nxt = 1'b0;
          w_state_nxt    = StWaitDone;
        end else if (w_timeout) begin
          w_tx_start_nxt = 1'b0;
          w_err_nxt      = 1'b1;
          w_state_nxt    = StRelease;
        end
      end
      StWaitDone: begin
        if (r_cnt != CntMax) w_cnt_nxt = r_cnt + 1'b1;
        // Completion takes precedence over a coincident timeout.
        if (io_bus.tx_done) begin
          w_done_nxt[r_gnt_id] = 1'b1;
          w_state_nxt          = StRelease;
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StRelease;
        end
      end
      StRelease: begin
        // Hold off until a level-held tx_done has dropped.
        if (!io_bus.tx_done && !io_bus.tx_busy) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and output registers; async reset discards any in-flight byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_last     <= LastInit;
      r_gnt_id   <= '0;
      r_tx_in    <= '0;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_done     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_tx_in    <= w_tx_in_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.tx_en     = io_bus.en;
  assign io_bus.tx_start  = r_tx_start;
  assign io_bus.tx_in     = r_tx_in;
  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.gnt_id    = r_gnt_id;
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` instance between `NREQ` byte-producing requesters. It accepts a byte from the winning requester with a valid/ready handshake and drives `tx_en`/`tx_start`/`tx_in` into `uart_tx`. It then tracks `tx_busy`/`tx_done` to completion and returns a per-requester completion or timeout pulse. It sits between client logic and `uart_tx`; `uart_tx` itself is instantiated outside this block.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width; must match `uart_tx.tx_in`
- `TIMEOUT_CYCLES`, 4096, maximum cycles from grant to `tx_done` before abort (≥ 4)
- `clk`  in  1  single clock for arbiter and `uart_tx`
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  arbiter enable; forwarded to `uart_tx.tx_en`
- `req_valid`  in  NREQ  requester i has a byte pending
- `req_data`  in  NREQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  NREQ  one-hot accept; byte i is captured on the edge where valid&ready
- `tx_en`  out  1  to `uart_tx.tx_en`
- `tx_start`  out  1  to `uart_tx.tx_start`
- `tx_in`  out  DATA_W  to `uart_tx.tx_in`; held for the whole transaction
- `tx_busy`  in  1  from `uart_tx`
- `tx_done`  in  1  from `uart_tx`
- `busy`  out  1  arbiter not in IDLE
- `gnt_id`  out  clog2(NREQ)  owner of the current or last transaction
- `done`  out  NREQ  one-cycle pulse to the owner on successful completion
- `err`  out  1  one-cycle timeout pulse; `gnt_id` identifies the owner

## Operation
- Reset values:
  - state IDLE
  - `req_ready`=0, `tx_start`=0, `tx_in`=0, `busy`=0, `gnt_id`=0, `done`=0, `err`=0
  - `tx_en`=`en` (combinational pass-through)
  - round-robin pointer `last`=NREQ-1, so requester 0 has first priority
- IDLE:
  - If `en`=1 and any `req_valid`, the winner is the first set bit scanning from `last`+1 with wrap modulo NREQ.
  - `req_ready[winner]`=1 combinationally in that cycle.
  - On that edge: `tx_in`←`req_data[winner]`, `gnt_id`←winner, `last`←winner, timeout counter←0, go to START.
  - If `en`=0, `req_ready`=0 and no grant is made.
- START:
  - `tx_start`=1 (registered).
  - When `tx_busy`=1 or `tx_done`=1, go to WAIT_DONE.
  - `tx_start` drops the cycle after the transition.
- WAIT_DONE:
  - On `tx_done`=1: pulse `done[gnt_id]`, go to RELEASE.
- RELEASE:
  - Wait until `tx_done`=0 and `tx_busy`=0, then go to IDLE.
  - This guards against a level-held `tx_done` being counted twice.
- Timeout:
  - The counter increments every cycle in START and WAIT_DONE; it is clog2(TIMEOUT_CYCLES)+1 bits and saturating.
  - On reaching TIMEOUT_CYCLES-1: pulse `err`, drop `tx_start`, go to RELEASE, and do not pulse `done`.
- `en` falling mid-transaction:
  - The current transaction continues to completion or timeout.
  - No new grant is made while `en`=0.
- Simultaneous `tx_done` and timeout in the same cycle: completion wins; `done` pulses and `err` does not.
- A requester dropping `req_valid` before it is granted is legal; it is simply skipped.
- `req_data` is ignored outside the grant cycle.

## Timing
- Grant latency: first `req_valid` at cycle N with the arbiter IDLE and `en`=1 gives `req_ready` in cycle N and `tx_start`=1 from cycle N+1.
- `tx_start` stays high until the cycle after `tx_busy` is first seen high (minimum 1 cycle).
- `done`/`err` assert exactly 1 cycle, on the edge following the cycle where `tx_done` or the timeout is sampled.
- Back-to-back throughput: next `req_ready` no earlier than 1 cycle after RELEASE sees `tx_done`=0 and `tx_busy`=0.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously), the captured byte is discarded, and no `done` is issued.

## Test plan
- Single request: req_valid=4'b0001, data 8'hAA; stub `uart_tx` asserts busy 2 cycles after start and done 100 cycles later -> `req_ready`[0] pulses once, `tx_in`=8'hAA, `done`=4'b0001 once, `err`=0.
- Fairness: all four valid continuously with data 8'h10..8'h13 -> grant order 0,1,2,3,0; each `done` bit pulses once per round.
- Timeout: TIMEOUT_CYCLES=16, stub never asserts `tx_done` -> `err` pulses at cycle 16 after the grant, `done`=0, and the next requester is granted afterwards.
- Level-held `tx_done` for 5 cycles -> exactly one `done` pulse; no new grant until `tx_done` falls.
- Enable gating: `en`=0 with req_valid=4'b0100 -> no `req_ready` for 50 cycles; `en`→1 -> grant 2 in the same cycle. Dropping `en` mid-transaction still gives `done`.
- Loopback with real `uart_tx`+`uart_rx`: requesters 1 and 3 send 8'h55 and 8'hC3 -> `rx_out` sequence 8'h55 then 8'hC3, `rx_err`=0. Assert `rst` mid-frame -> `busy`=0 and `tx_start`=0 at once, no `done` pulse.
